// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: services 8-beat read/write line bursts from an internal word array.
// Optional SYSBUS_MEM_CRIT_WORD_EN: bursts start at the addressed (critical) word and wrap within the line.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 2,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    output logic                      busy
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_LAT,
        RESP,
        WR_DATA
    } state_t;

    state_t                    state, state_nxt;
    logic [AW-4:0]             line_q, line_nxt;
    logic [2:0]                start_q, start_nxt;
    logic [2:0]                beat_q, beat_nxt;
    logic [7:0]                lat_q, lat_nxt;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_nxt;
    logic                      respcyc_nxt;
    logic [BUS_DATA_WIDTH-1:0] resp_nxt;
    logic [BUS_TAG_WIDTH-1:0]  resptag_nxt;
    logic                      mem_we;
    logic [AW-1:0]             word_idx;
    logic [AW-1:0]             rd_idx;
    logic [AW-1:0]             req_idx;
    logic [2:0]                hdr_start;
    logic                      unused_req_bits;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    assign req_idx         = bus_req[3+AW-1:3];
    assign word_idx        = {line_q, 3'(start_q + beat_q)};
    assign unused_req_bits = ^{bus_req[BUS_DATA_WIDTH-1:3+AW], bus_req[2:0]};

`ifdef SYSBUS_MEM_CRIT_WORD_EN
    assign hdr_start = bus_req[5:3];
`else
    assign hdr_start = 3'd0;
`endif

    always_comb begin
        state_nxt   = state;
        line_nxt    = line_q;
        start_nxt   = start_q;
        beat_nxt    = beat_q;
        lat_nxt     = lat_q;
        tag_nxt     = tag_q;
        respcyc_nxt = bus_respcyc;
        resp_nxt    = bus_resp;
        resptag_nxt = bus_resptag;
        mem_we      = 1'b0;
        bus_reqack  = 1'b0;
        rd_idx      = word_idx;

        case (state)
            IDLE: begin
                if (bus_reqcyc && bus_reqtag[11:8] == `SYSBUS_MEMORY) begin
                    bus_reqack = 1'b1;
                    line_nxt   = req_idx[AW-1:3];
                    start_nxt  = hdr_start;
                    beat_nxt   = 3'd0;
                    if (bus_reqtag[12] == `SYSBUS_READ) begin
                        tag_nxt   = bus_reqtag;
                        lat_nxt   = 8'(READ_LATENCY - 1);
                        state_nxt = RD_LAT;
                    end else begin
                        state_nxt = WR_DATA;
                    end
                end
            end
            RD_LAT: begin
                if (lat_q == '0) begin
                    respcyc_nxt = 1'b1;
                    resp_nxt    = mem[rd_idx];
                    resptag_nxt = tag_q;
                    state_nxt   = RESP;
                end else begin
                    lat_nxt = lat_q - 8'd1;
                end
            end
            RESP: begin
                // Prefetch the next word on an acked beat so beats can stream back-to-back.
                if (bus_respack) begin
                    if (beat_q == LAST_BEAT) begin
                        respcyc_nxt = 1'b0;
                        beat_nxt    = 3'd0;
                        state_nxt   = IDLE;
                    end else begin
                        beat_nxt = beat_q + 3'd1;
                        rd_idx   = {line_q, 3'(start_q + beat_q + 3'd1)};
                        resp_nxt = mem[rd_idx];
                    end
                end
            end
            WR_DATA: begin
                bus_reqack = bus_reqcyc;
                if (bus_reqcyc) begin
                    mem_we   = 1'b1;
                    beat_nxt = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            line_q      <= '0;
            start_q     <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
            tag_q       <= '0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            line_q      <= line_nxt;
            start_q     <= start_nxt;
            beat_q      <= beat_nxt;
            lat_q       <= lat_nxt;
            tag_q       <= tag_nxt;
            bus_respcyc <= respcyc_nxt;
            bus_resp    <= resp_nxt;
            bus_resptag <= resptag_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

    // Array is never cleared; a beat presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[word_idx] <= bus_req;
        end
    end

endmodule
